clock_divider_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-output clock divider.
- Produces NCH independent divided-clock levels and single-cycle clock-enable ticks from CLK.
- Each channel has a runtime-programmable divisor, changed glitch-free at period boundaries, plus a global phase-align (sync) input.
- Feeds CPU/peripheral clock-enable logic. The divclk outputs are data signals for logic use, not clock-tree drivers.

---
 rtl/clock_divider_multi.sv | 118 +++++++++++
 tb/tb_clock_divider_multi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NCH independent programmable clock dividers.
// Each channel produces a registered divided-clock level (divclk) and a
// one-cycle tick at the start of every period. A new divisor is captured
// into a pending slot and only takes effect at a period boundary (wrap)
// or on a global sync, so divclk never shows a runt phase. A stored
// divisor of 0 behaves like 1. Odd divisors give the extra cycle to the
// high phase. divclk is a data signal for enable logic, not a clock-tree
// driver.
module clock_divider_multi #(
    parameter int NCH         = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH-1:0]       div_load,
    input  logic [NCH*DIV_W-1:0] div_value,
    input  logic                 sync,
    output logic [NCH-1:0]       divclk,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       div_pending
);

    logic [DIV_W-1:0] cnt_q   [NCH];
    logic [DIV_W-1:0] cnt_d   [NCH];
    logic [DIV_W-1:0] dact_q  [NCH];
    logic [DIV_W-1:0] dact_d  [NCH];
    logic [DIV_W-1:0] dpend_q [NCH];
    logic [DIV_W-1:0] dpend_d [NCH];
    logic [NCH-1:0]   pend_q,   pend_d;
    logic [NCH-1:0]   divclk_q, divclk_d;
    logic [NCH-1:0]   tick_q,   tick_d;

    // Effective divisor: a stored 0 counts as 1.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    // Length of the high phase: ceil(Deff/2), one bit wider to avoid overflow.
    function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] d);
        logic [DIV_W:0] e;
        e = {1'b0, eff_div(d)};
        return (e + (DIV_W+1)'(1)) >> 1;
    endfunction

    // Next-state logic per channel: sync beats counting; loads land in the pending slot.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            dact_d[i]   = dact_q[i];
            dpend_d[i]  = dpend_q[i];
            pend_d[i]   = pend_q[i];
            divclk_d[i] = divclk_q[i];
            tick_d[i]   = 1'b0;
            if (sync) begin
                // Restart at phase 0; a load in this cycle supersedes any older pending value.
                cnt_d[i] = '0;
                if (div_load[i]) begin
                    dact_d[i]  = div_value[i*DIV_W +: DIV_W];
                    dpend_d[i] = div_value[i*DIV_W +: DIV_W];
                    pend_d[i]  = 1'b0;
                end else if (pend_q[i]) begin
                    dact_d[i] = dpend_q[i];
                    pend_d[i] = 1'b0;
                end
                divclk_d[i] = 1'b1;
                tick_d[i]   = enable[i];
            end else begin
                if (enable[i]) begin
                    // >= rather than == keeps the counter safe from any out-of-range state.
                    if (cnt_q[i] >= eff_div(dact_q[i]) - DIV_W'(1)) begin
                        cnt_d[i]  = '0;
                        tick_d[i] = 1'b1;
                        if (pend_q[i]) begin
                            dact_d[i] = dpend_q[i];
                            pend_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + DIV_W'(1);
                    end
                    divclk_d[i] = ({1'b0, cnt_d[i]} < high_len(dact_d[i]));
                end
                // Applied after the wrap so a same-cycle load waits for the following wrap.
                if (div_load[i]) begin
                    dpend_d[i] = div_value[i*DIV_W +: DIV_W];
                    pend_d[i]  = 1'b1;
                end
            end
        end
    end

    // State and output registers; reset reloads the default divisor one step before wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= DIV_W'(DEFAULT_DIV - 1);
                dact_q[i]  <= DIV_W'(DEFAULT_DIV);
                dpend_q[i] <= DIV_W'(DEFAULT_DIV);
            end
            pend_q   <= '0;
            divclk_q <= '0;
            tick_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            dact_q   <= dact_d;
            dpend_q  <= dpend_d;
            pend_q   <= pend_d;
            divclk_q <= divclk_d;
            tick_q   <= tick_d;
        end
    end

    assign divclk      = divclk_q;
    assign tick        = tick_q;
    assign div_pending = pend_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (NCH=2, DIV_W=8, DEFAULT_DIV=2).
module tb_clock_divider_multi;

    logic        CLK;
    logic        RST;
    logic [1:0]  enable;
    logic [1:0]  div_load;
    logic [15:0] div_value;
    logic        sync;
    logic [1:0]  divclk;
    logic [1:0]  tick;
    logic [1:0]  div_pending;

    int checks = 0;
    int errors = 0;

    clock_divider_multi #(.NCH(2), .DIV_W(8), .DEFAULT_DIV(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (enable),
        .div_load    (div_load),
        .div_value   (div_value),
        .sync        (sync),
        .divclk      (divclk),
        .tick        (tick),
        .div_pending (div_pending)
    );

    // clock / watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // advance one rising edge, then settle away from it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_dc,
                             input logic [1:0] e_tk, input logic [1:0] e_pd);
        check({tag, ".divclk"}, {30'd0, divclk}, {30'd0, e_dc});
        check({tag, ".tick"}, {30'd0, tick}, {30'd0, e_tk});
        check({tag, ".pend"}, {30'd0, div_pending}, {30'd0, e_pd});
    endtask

    // ch0 expectations for the mid-period change sequence (15 cycles)
    int p3_dc[15] = '{1,1,1,0,0,0,0,1,1,0,1,1,0,0,1};
    int p3_tk[15] = '{0,0,0,0,0,0,0,1,0,0,1,0,0,0,1};
    int p3_pd[15] = '{0,0,0,1,1,1,1,1,1,1,0,0,0,0,0};
    // ch0 expectations for the enable-gap sequence (20 cycles)
    int p4_dc[20] = '{1,0,0,1,1,1,1,1,1,1,0,0,0,1,1,1,0,0,0,1};
    int p4_tk[20] = '{0,0,0,1,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,1};
    int p4_pd[20] = '{1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    // odd divisor sequence (both channels, 5 cycles)
    logic [1:0] p2_dc[5] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
    logic [1:0] p2_tk[5] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10};

    initial begin
        RST       = 1'b1;
        enable    = 2'b00;
        div_load  = 2'b00;
        div_value = 16'h0000;
        sync      = 1'b0;

        // reset and default divide-by-2
        step();
        step();
        check_all("reset", 2'b00, 2'b00, 2'b00);
        check("reset.cnt0", {24'd0, dut.cnt_q[0]}, 32'd1);
        RST    = 1'b0;
        enable = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            check_all($sformatf("div2[%0d]", i), (i % 2 == 0) ? 2'b11 : 2'b00,
                      (i % 2 == 0) ? 2'b11 : 2'b00, 2'b00);
        end

        // odd divisor 5 on ch1 loaded at cnt=0
        step();
        div_load  = 2'b10;
        div_value = 16'h0500;
        step();
        div_load = 2'b00;
        check_all("odd.load", 2'b00, 2'b00, 2'b10);
        step();
        check_all("odd.apply", 2'b11, 2'b11, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("odd[%0d]", i), p2_dc[i], p2_tk[i], 2'b00);
        end

        // ch1 parked; ch0 gets 8 via a load in a wrap cycle
        enable    = 2'b01;
        div_load  = 2'b01;
        div_value = 16'h0008;
        step();
        div_load = 2'b00;
        check_all("d8.loadwrap", 2'b11, 2'b01, 2'b01);
        step();
        check_all("d8.wait", 2'b10, 2'b00, 2'b01);
        step();
        check_all("d8.apply", 2'b11, 2'b01, 2'b00);

        // mid-period change 8 -> 3, then 4 loaded in the wrap cycle
        for (int i = 0; i < 15; i++) begin
            if (i == 3) begin
                div_load  = 2'b01;
                div_value = 16'h0003;
            end else if (i == 7) begin
                div_load  = 2'b01;
                div_value = 16'h0004;
            end else begin
                div_load = 2'b00;
            end
            step();
            check_all($sformatf("mid[%0d]", i), {1'b1, p3_dc[i][0]},
                      {1'b0, p3_tk[i][0]}, {1'b0, p3_pd[i][0]});
        end
        div_load = 2'b00;

        // enable gap on a divide-by-6 period
        for (int i = 0; i < 20; i++) begin
            enable    = (i >= 6 && i <= 9) ? 2'b00 : 2'b01;
            div_load  = (i == 0) ? 2'b01 : 2'b00;
            div_value = 16'h0006;
            step();
            check_all($sformatf("gap[%0d]", i), {1'b1, p4_dc[i][0]},
                      {1'b0, p4_tk[i][0]}, {1'b0, p4_pd[i][0]});
        end
        div_load = 2'b00;

        // sync alignment: ch0 pending 4, ch1 loads 6 in the sync cycle
        enable    = 2'b11;
        div_load  = 2'b01;
        div_value = 16'h0004;
        step();
        div_load = 2'b00;
        check("sync.pend", {30'd0, div_pending}, 32'd1);
        step();
        step();
        sync      = 1'b1;
        div_load  = 2'b10;
        div_value = 16'h0600;
        step();
        sync     = 1'b0;
        div_load = 2'b00;
        check_all("sync", 2'b11, 2'b11, 2'b00);
        for (int j = 1; j <= 12; j++) begin
            step();
            check_all($sformatf("align[%0d]", j),
                      {((j % 6) < 3) ? 1'b1 : 1'b0, ((j % 4) < 2) ? 1'b1 : 1'b0},
                      {(j % 6 == 0) ? 1'b1 : 1'b0, (j % 4 == 0) ? 1'b1 : 1'b0},
                      2'b00);
        end

        // divisors 0 and 1 applied through sync
        div_load  = 2'b11;
        div_value = 16'h0100;
        step();
        div_load = 2'b00;
        check("d01.pend", {30'd0, div_pending}, 32'd3);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_all("d01.sync", 2'b11, 2'b11, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            check_all($sformatf("d01[%0d]", i), 2'b11, 2'b11, 2'b00);
        end

        // reset mid-period with a pending divisor
        div_load  = 2'b01;
        div_value = 16'h0007;
        step();
        div_load = 2'b00;
        check_all("d7.load", 2'b11, 2'b11, 2'b01);
        step();
        check_all("d7.apply", 2'b11, 2'b11, 2'b00);
        step();
        step();
        div_load  = 2'b01;
        div_value = 16'h0003;
        step();
        div_load = 2'b00;
        check_all("rstmid.pre", 2'b11, 2'b10, 2'b01);
        check("rstmid.cnt", {24'd0, dut.cnt_q[0]}, 32'd3);
        check("rstmid.dact", {24'd0, dut.dact_q[0]}, 32'd7);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_all("rstmid", 2'b00, 2'b00, 2'b00);
        check("rstmid.cnt0", {24'd0, dut.cnt_q[0]}, 32'd1);
        check("rstmid.dact0", {24'd0, dut.dact_q[0]}, 32'd2);
        step();
        check_all("post.first", 2'b11, 2'b11, 2'b00);
        step();
        check_all("post.second", 2'b00, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
